// File: rtl/cpu_pkg.sv
// Shared types for the CPU branch/flag logic: condition codes, flag layout
// and the condition decoder used by condition_flags_unit.
package cpu_pkg;

  // Bit positions of each flag within the packed {z,n,c,v} word
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_NEVER = 4'b0000,
    COND_EQ    = 4'b0001,
    COND_LT    = 4'b0010,
    COND_LE    = 4'b0011,
    COND_AL    = 4'b0100,
    COND_NE    = 4'b0101,
    COND_GT    = 4'b0110,
    COND_GE    = 4'b0111,
    COND_CS    = 4'b1000,
    COND_CC    = 4'b1001,
    COND_HI    = 4'b1010,
    COND_LS    = 4'b1011,
    COND_MI    = 4'b1100,
    COND_PL    = 4'b1101,
    COND_VS    = 4'b1110,
    COND_VC    = 4'b1111
  } cond_code_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  // Evaluate one condition code against a flag set
  function automatic logic cond_eval(input cond_code_t code, input flags_t f);
    logic lt;
    logic res;
    lt  = f.n ^ f.v;
    res = 1'b0;
    case (code)
      COND_NEVER: res = 1'b0;
      COND_EQ:    res = f.z;
      COND_LT:    res = lt;
      COND_LE:    res = f.z | lt;
      COND_AL:    res = 1'b1;
      COND_NE:    res = ~f.z;
      COND_GT:    res = ~f.z & ~lt;
      COND_GE:    res = ~lt;
      COND_CS:    res = f.c;
      COND_CC:    res = ~f.c;
      COND_HI:    res = f.c & ~f.z;
      COND_LS:    res = ~f.c | f.z;
      COND_MI:    res = f.n;
      COND_PL:    res = ~f.n;
      COND_VS:    res = f.v;
      COND_VC:    res = ~f.v;
      default:    res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/flag_stack.sv
// LIFO of flag words used to save/restore flags around interrupts.
// Push and pop together on a non-empty stack swaps the top entry with the
// incoming flags; overflow/underflow are single-cycle event pulses.
module flag_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  flags_t        din,
  output flags_t        top,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          overflow,
  output logic          underflow
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  flags_t          mem [DEPTH];
  logic [CW-1:0]   count_reg;
  logic [IW-1:0]   top_idx;
  logic [IW-1:0]   wr_idx;
  logic            full;
  logic            swap;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  // Index arithmetic is only meaningful when the matching status allows it
  assign top_idx = IW'(count_reg - 1'b1);
  assign wr_idx  = IW'(count_reg);

  assign swap     = push & pop & ~empty;
  assign do_push  = push & ~full & ~swap;
  assign do_pop   = pop & ~empty & ~swap;
  assign overflow  = push & full & ~swap;
  assign underflow = pop & empty;

  assign top   = mem[top_idx];
  assign count = count_reg;

  // Occupancy counter; push and pop never both act outside a swap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (do_push) begin
      count_reg <= count_reg + 1'b1;
    end else if (do_pop) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  // Entry storage; contents need no reset since count gates every read
  always_ff @(posedge clock) begin
    if (swap) begin
      mem[top_idx] <= din;
    end else if (do_push) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/condition_flags_unit.sv
// Branch-condition unit: Z/N/C/V flag register fed by the ALU, a flag
// save/restore stack, and a registered condition evaluator (1-cycle latency).
module condition_flags_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4,
  parameter int BYPASS      = 0,
  localparam int CW = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             flags_we,
  input  logic             flags_push,
  input  logic             flags_pop,
  input  logic             cond_valid,
  input  logic [3:0]       cond_code,
  output logic             result,
  output logic             result_valid,
  output logic [3:0]       flags,
  output logic [CW-1:0]    stack_count,
  output logic             stack_error
);

  flags_t flags_reg;
  flags_t flags_next;
  flags_t alu_flags;
  flags_t eval_flags;
  flags_t stack_top;
  logic   stack_empty;
  logic   stack_overflow;
  logic   stack_underflow;
  logic   pop_ok;
  logic   result_reg;
  logic   result_valid_reg;
  logic   error_reg;

  flag_stack #(
    .DEPTH(STACK_DEPTH)
  ) u_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (flags_push),
    .pop       (flags_pop),
    .din       (flags_reg),
    .top       (stack_top),
    .count     (stack_count),
    .empty     (stack_empty),
    .overflow  (stack_overflow),
    .underflow (stack_underflow)
  );

  assign pop_ok = flags_pop & ~stack_empty;

  // Flags derived from the current ALU outputs
  always_comb begin
    alu_flags   = '0;
    alu_flags.z = (alu_result == '0);
    alu_flags.n = alu_result[WIDTH-1];
    alu_flags.c = alu_carry;
    alu_flags.v = alu_overflow;
  end

  // Next flag value: a successful pop wins over an ALU write
  always_comb begin
    flags_next = flags_reg;
    if (pop_ok) begin
      flags_next = stack_top;
    end else if (flags_we) begin
      flags_next = alu_flags;
    end
  end

  assign eval_flags = (BYPASS != 0) ? flags_next : flags_reg;

  // Flag register, registered condition result and sticky stack error
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flags_reg        <= '0;
      result_reg       <= 1'b0;
      result_valid_reg <= 1'b0;
      error_reg        <= 1'b0;
    end else begin
      flags_reg        <= flags_next;
      result_valid_reg <= cond_valid;
      if (cond_valid) begin
        result_reg <= cond_eval(cond_code_t'(cond_code), eval_flags);
      end
      if (stack_overflow || stack_underflow) begin
        error_reg <= 1'b1;
      end
    end
  end

  // Present the flag register in {Z,N,C,V} order
  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = flags_reg.z;
    flags[FLAG_N] = flags_reg.n;
    flags[FLAG_C] = flags_reg.c;
    flags[FLAG_V] = flags_reg.v;
  end

  assign result       = result_reg;
  assign result_valid = result_valid_reg;
  assign stack_error  = error_reg;

endmodule
